// File: rtl/riscv_ram_nrw_if.sv
// Request/grant bus between PORTS requesters and the shared riscv_ram_nrw memory.
// Per-port fields are packed with port p at slice [p*W +: W].
interface riscv_ram_nrw_if #(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32,
    parameter int unsigned PORTS = 2
);
    localparam int unsigned BEBITS = (DBITS + 7) / 8;

    logic [PORTS-1:0]        req_i;
    logic [PORTS-1:0]        gnt_o;
    logic [PORTS*ABITS-1:0]  addr_i;
    logic [PORTS-1:0]        we_i;
    logic [PORTS*BEBITS-1:0] be_i;
    logic [PORTS*DBITS-1:0]  din_i;
    logic [DBITS-1:0]        dout_o;
    logic [PORTS-1:0]        rvalid_o;

    modport master (
        output req_i, addr_i, we_i, be_i, din_i,
        input  gnt_o, dout_o, rvalid_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, din_i,
        output gnt_o, dout_o, rvalid_o
    );
endinterface

// File: rtl/riscv_ram_nrw.sv
// Shared single-port memory for PORTS requesters: round-robin grant, byte-enabled
// writes and a registered one-cycle read path with a one-hot read-valid.
module riscv_ram_nrw #(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32,
    parameter int unsigned PORTS = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    riscv_ram_nrw_if.slave bus
);
    localparam int unsigned BEBITS = (DBITS + 7) / 8;
    localparam int unsigned TOPW   = DBITS - 8 * (BEBITS - 1);
    localparam int unsigned PW     = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0]  w_gnt;
    logic [PW-1:0]     w_sel;
    logic              w_accept;
    logic [ABITS-1:0]  w_addr;
    logic              w_we;
    logic [BEBITS-1:0] w_be;
    logic [DBITS-1:0]  w_din;

    logic [DBITS-1:0]  r_mem [2**ABITS];
    logic [DBITS-1:0]  r_dout;
    logic [PORTS-1:0]  r_rvalid;

    generate
        if (PORTS == 1) begin : g_single
            assign w_gnt = bus.req_i;
            assign w_sel = '0;
        end else begin : g_rr
            logic [PW-1:0] r_ptr;
            logic [PW-1:0] w_idx;
            logic          w_found;

            // Search from r_ptr upward, wrapping at PORTS; first requester wins.
            always_comb begin
                w_gnt   = '0;
                w_sel   = '0;
                w_idx   = '0;
                w_found = 1'b0;
                for (int i = 0; i < int'(PORTS); i++) begin
                    w_idx = PW'((int'(r_ptr) + i) % int'(PORTS));
                    if (!w_found && bus.req_i[w_idx]) begin
                        w_found      = 1'b1;
                        w_gnt[w_idx] = 1'b1;
                        w_sel        = w_idx;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_ptr <= '0;
                end else if (w_accept) begin
                    r_ptr <= PW'((int'(w_sel) + 1) % int'(PORTS));
                end
            end
        end
    endgenerate

    assign w_accept = |(bus.req_i & w_gnt);
    assign w_addr   = bus.addr_i[w_sel*ABITS +: ABITS];
    assign w_we     = bus.we_i[w_sel];
    assign w_be     = bus.be_i[w_sel*BEBITS +: BEBITS];
    assign w_din    = bus.din_i[w_sel*DBITS +: DBITS];

    // Storage is deliberately not reset; rst_ni only blocks writes while asserted.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_we && rst_ni) begin
            for (int b = 0; b < int'(BEBITS) - 1; b++) begin
                if (w_be[b]) begin
                    r_mem[w_addr][b*8 +: 8] <= w_din[b*8 +: 8];
                end
            end
            if (w_be[BEBITS-1]) begin
                r_mem[w_addr][8*(BEBITS-1) +: TOPW] <= w_din[8*(BEBITS-1) +: TOPW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dout   <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= (w_accept && !w_we) ? w_gnt : '0;
            if (w_accept && !w_we) begin
                r_dout <= r_mem[w_addr];
            end
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.dout_o   = r_dout;
    assign bus.rvalid_o = r_rvalid;
endmodule

// File: tb/tb_riscv_ram_nrw.sv
// Directed bench for riscv_ram_nrw with three ports: vector table plus hand-written
// round-robin and reset-during-read sequences.
module tb_riscv_ram_nrw;
    localparam int unsigned ABITS = 10;
    localparam int unsigned DBITS = 32;
    localparam int unsigned PORTS = 3;

    logic clk_i;
    logic rst_ni;

    riscv_ram_nrw_if #(.ABITS(ABITS), .DBITS(DBITS), .PORTS(PORTS)) bus ();

    riscv_ram_nrw #(.ABITS(ABITS), .DBITS(DBITS), .PORTS(PORTS)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  req;
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_rvalid;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[14];
    int   n_checks;
    int   n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Same payload on every port; only req decides who participates.
    task automatic drive(input logic [2:0] req, input logic we, input logic [9:0] addr,
                         input logic [3:0] be, input logic [31:0] din);
        bus.req_i  = req;
        bus.we_i   = {PORTS{we}};
        bus.addr_i = {PORTS{addr}};
        bus.be_i   = {PORTS{be}};
        bus.din_i  = {PORTS{din}};
    endtask

    task automatic set_vec(input int i, input logic [2:0] req, input logic we,
                           input logic [9:0] addr, input logic [3:0] be, input logic [31:0] din,
                           input logic [2:0] eg, input logic [2:0] er, input logic [31:0] ed);
        vecs[i].req = req;   vecs[i].we = we;        vecs[i].addr = addr;
        vecs[i].be = be;     vecs[i].din = din;      vecs[i].exp_gnt = eg;
        vecs[i].exp_rvalid = er;                     vecs[i].exp_dout = ed;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        //          req     we    addr   be    din            gnt     rvalid  dout
        set_vec(0,  3'b001, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 3'b001, 3'b000, 32'h0);
        set_vec(1,  3'b001, 1'b0, 10'd5, 4'h0, 32'h0,        3'b001, 3'b001, 32'hDEADBEEF);
        set_vec(2,  3'b001, 1'b1, 10'd3, 4'hF, 32'h11223344, 3'b001, 3'b000, 32'hDEADBEEF);
        set_vec(3,  3'b001, 1'b1, 10'd3, 4'h5, 32'hAABBCCDD, 3'b001, 3'b000, 32'hDEADBEEF);
        set_vec(4,  3'b001, 1'b0, 10'd3, 4'h0, 32'h0,        3'b001, 3'b001, 32'h11BB33DD);
        set_vec(5,  3'b001, 1'b1, 10'd3, 4'h0, 32'hFFFFFFFF, 3'b001, 3'b000, 32'h11BB33DD);
        set_vec(6,  3'b001, 1'b0, 10'd3, 4'h0, 32'h0,        3'b001, 3'b001, 32'h11BB33DD);
        set_vec(7,  3'b100, 1'b1, 10'd1, 4'hF, 32'h1,        3'b100, 3'b000, 32'h11BB33DD);
        set_vec(8,  3'b010, 1'b1, 10'd2, 4'hF, 32'h2,        3'b010, 3'b000, 32'h11BB33DD);
        set_vec(9,  3'b001, 1'b0, 10'd1, 4'h0, 32'h0,        3'b001, 3'b001, 32'h1);
        set_vec(10, 3'b010, 1'b0, 10'd2, 4'h0, 32'h0,        3'b010, 3'b010, 32'h2);
        set_vec(11, 3'b000, 1'b0, 10'd2, 4'h0, 32'h0,        3'b000, 3'b000, 32'h2);
        set_vec(12, 3'b010, 1'b1, 10'd9, 4'hF, 32'hCAFE0000, 3'b010, 3'b000, 32'h2);
        set_vec(13, 3'b001, 1'b0, 10'd9, 4'h0, 32'h0,        3'b001, 3'b001, 32'hCAFE0000);

        rst_ni = 1'b0;
        drive(3'b010, 1'b1, 10'd5, 4'hF, 32'h0);
        #1;
        check("gnt_during_reset", 32'(bus.gnt_o), 32'(3'b010));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        drive(3'b000, 1'b0, 10'd0, 4'h0, 32'h0);
        rst_ni = 1'b1;
        #1;
        check("reset_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("reset_dout", bus.dout_o, 32'h0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].din);
            #1;
            check($sformatf("vec%0d_gnt", i), 32'(bus.gnt_o), 32'(vecs[i].exp_gnt));
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d_rvalid", i), 32'(bus.rvalid_o), 32'(vecs[i].exp_rvalid));
            check($sformatf("vec%0d_dout", i), bus.dout_o, vecs[i].exp_dout);
        end

        // Round-robin from a fresh reset, all ports issuing no-op writes.
        @(negedge clk_i);
        drive(3'b000, 1'b0, 10'd0, 4'h0, 32'h0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic [2:0] exp_g;
            exp_g = 3'b001 << (c % 3);
            @(negedge clk_i);
            drive(3'b111, 1'b1, 10'd0, 4'h0, 32'h0);
            #1;
            check($sformatf("rr_all_%0d", c), 32'(bus.gnt_o), 32'(exp_g));
            @(posedge clk_i);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            drive(3'b010, 1'b1, 10'd0, 4'h0, 32'h0);
            #1;
            check($sformatf("rr_p1_%0d", c), 32'(bus.gnt_o), 32'(3'b010));
            @(posedge clk_i);
        end

        // Move the pointer off 0, then reset while a read's rvalid is showing.
        @(negedge clk_i);
        drive(3'b001, 1'b0, 10'd5, 4'h0, 32'h0);
        @(posedge clk_i);
        #1;
        check("pre_reset_rvalid", 32'(bus.rvalid_o), 32'(3'b001));
        check("pre_reset_dout", bus.dout_o, 32'hDEADBEEF);
        drive(3'b000, 1'b0, 10'd0, 4'h0, 32'h0);
        rst_ni = 1'b0;
        #1;
        check("mid_reset_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("mid_reset_dout", bus.dout_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(3'b111, 1'b0, 10'd3, 4'h0, 32'h0);
        #1;
        check("post_reset_ptr", 32'(bus.gnt_o), 32'(3'b001));
        @(posedge clk_i);
        #1;
        check("preserved_rvalid", 32'(bus.rvalid_o), 32'(3'b001));
        check("preserved_dout", bus.dout_o, 32'h11BB33DD);
        @(negedge clk_i);
        drive(3'b111, 1'b0, 10'd5, 4'h0, 32'h0);
        #1;
        check("post_reset_rr", 32'(bus.gnt_o), 32'(3'b010));
        @(posedge clk_i);
        #1;
        check("preserved2_rvalid", 32'(bus.rvalid_o), 32'(3'b010));
        check("preserved2_dout", bus.dout_o, 32'hDEADBEEF);

        @(negedge clk_i);
        drive(3'b000, 1'b0, 10'd0, 4'h0, 32'h0);
        @(posedge clk_i);
        #1;
        check("idle_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("idle_dout_hold", bus.dout_o, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
